// File: rtl/sight_pkg.sv
// Shared types, constants and helpers for the visual-acuity test sequencer.
package sight_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHOW,
    ST_WAIT,
    ST_JUDGE,
    ST_DONE
  } state_t;

  // Orientation encoding shared by dir and the key bit positions
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam int MAX_LEVEL = 10;

  // Level k (tenths) to {tenths digit, integer digit}; 10 reads as "1.0"
  function automatic logic [7:0] level_to_bcd(input logic [3:0] k);
    if (k == 4'd0)
      return 8'h00;
    else if (k >= 4'(MAX_LEVEL))
      return 8'h01;
    else
      return {k, 4'h0};
  endfunction

  // The only key pattern that counts as a correct answer for orientation d
  function automatic logic [3:0] dir_to_key(input logic [1:0] d);
    case (d)
      DIR_UP:    return 4'b0001;
      DIR_RIGHT: return 4'b0010;
      DIR_DOWN:  return 4'b0100;
      DIR_LEFT:  return 4'b1000;
      default:   return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/sight_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) picking chart orientations.
module sight_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clkout,
  input  logic       rst_n,
  output logic [1:0] rnd
);

  logic [7:0] lfsr;

  assign rnd = lfsr[1:0];

  // Shift every cycle; a nonzero seed keeps the maximal sequence off zero
  always_ff @(posedge clkout or posedge rst_n) begin
    if (rst_n)
      lfsr <= SEED;
    else
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

endmodule

// File: rtl/sight_test_ctrl.sv
// Acuity test sequencer: steps levels 0.1..1.0, presents orientations, scores keys.
// Note: rst_n is active-high asynchronous, as in the rest of this codebase.
module sight_test_ctrl
  import sight_pkg::*;
#(
  parameter int         N_TRIALS  = 5,
  parameter int         PASS_MIN  = 3,
  parameter int         TIMEOUT   = 50,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clkout,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] key,
  output logic [7:0] bcd,
  output logic       X_signal,
  output logic [1:0] dir,
  output logic       dir_valid,
  output logic       busy,
  output logic       done
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        state;
  logic [3:0]    lvl;
  logic [2:0]    c_cnt, w_cnt;
  logic [TW-1:0] tmr;
  logic          hit;
  logic [1:0]    rnd;
  logic [2:0]    c_nxt, w_nxt;

  sight_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clkout (clkout),
    .rst_n  (rst_n),
    .rnd    (rnd)
  );

  // Counts as they stand after the answer held in hit is scored
  assign c_nxt = c_cnt + {2'b00, hit};
  assign w_nxt = w_cnt + {2'b00, ~hit};

  // Test sequencer with registered outputs
  always_ff @(posedge clkout or posedge rst_n) begin
    if (rst_n) begin
      state     <= ST_IDLE;
      lvl       <= 4'd0;
      c_cnt     <= 3'd0;
      w_cnt     <= 3'd0;
      tmr       <= '0;
      hit       <= 1'b0;
      bcd       <= 8'h00;
      X_signal  <= 1'b0;
      dir       <= 2'd0;
      dir_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state    <= ST_SHOW;
            lvl      <= 4'd1;
            c_cnt    <= 3'd0;
            w_cnt    <= 3'd0;
            bcd      <= level_to_bcd(4'd1);
            X_signal <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
        ST_SHOW: begin
          dir       <= rnd;
          tmr       <= '0;
          dir_valid <= 1'b1;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          // A key on the expiry cycle wins over the timeout
          if (key != 4'd0) begin
            hit       <= (key == dir_to_key(dir));
            dir_valid <= 1'b0;
            state     <= ST_JUDGE;
          end else if (tmr == TW'(TIMEOUT - 1)) begin
            hit       <= 1'b0;
            dir_valid <= 1'b0;
            state     <= ST_JUDGE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_JUDGE: begin
          c_cnt <= c_nxt;
          w_cnt <= w_nxt;
          if (c_nxt == 3'(PASS_MIN)) begin
            if (lvl == 4'(MAX_LEVEL)) begin
              bcd   <= level_to_bcd(4'(MAX_LEVEL));
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              lvl   <= lvl + 4'd1;
              c_cnt <= 3'd0;
              w_cnt <= 3'd0;
              bcd   <= level_to_bcd(lvl + 4'd1);
              state <= ST_SHOW;
            end
          end else if (w_nxt > 3'(N_TRIALS - PASS_MIN)) begin
            // Result is the last level passed; failing level 1 is below scale
            bcd      <= level_to_bcd(lvl - 4'd1);
            X_signal <= (lvl == 4'd1);
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= ST_DONE;
          end else begin
            state <= ST_SHOW;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
